// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, FXU opcodes and the CDB lane record.
package core_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ROB_IDX_W = 4;
  localparam int unsigned IMM_W     = 8;
  localparam int unsigned OPC_W     = 4;

  localparam logic [OPC_W-1:0] OPC_SUB  = 4'h0;
  localparam logic [OPC_W-1:0] OPC_MOVL = 4'h8;
  localparam logic [OPC_W-1:0] OPC_MOVH = 4'h9;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [DATA_W-1:0]    result;
  } cdb_lane_t;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/fxu_alu.sv
// Combinational FXU datapath: opcode and operands to a DATA_W-wide result.
module fxu_alu
  import core_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode_i,
  input  logic [DATA_W-1:0] op1_i,
  input  logic [DATA_W-1:0] op2_i,
  input  logic [IMM_W-1:0]  imm_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (opcode_i)
      OPC_SUB:  result_o = op1_i - op2_i;
      OPC_MOVL: result_o = sext_imm(imm_i);
      OPC_MOVH: result_o = {imm_i, op1_i[DATA_W-IMM_W-1:0]};
      // Unknown opcodes still retire (with zero) so the ROB entry completes.
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/fxu_exec.sv
// Fixed-point execution unit: LATENCY-deep valid/tag/result pipe feeding one CDB lane.
module fxu_exec
  import core_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [OPC_W-1:0]     opcode,
  input  logic [ROB_IDX_W-1:0] rob_idx,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    op1,
  input  logic [DATA_W-1:0]    op2,
  input  logic [IMM_W-1:0]     imm,
  output logic                 cdb_valid,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx,
  output logic [DATA_W-1:0]    cdb_result
);

  if (LATENCY < 1 || LATENCY > 4) begin : g_latency_check
    $error("fxu_exec: LATENCY must be in 1..4");
  end

  logic [DATA_W-1:0] alu_result;
  logic              issue;
  cdb_lane_t         stage_q [LATENCY];

  fxu_alu u_alu (
    .opcode_i (opcode),
    .op1_i    (op1),
    .op2_i    (op2),
    .imm_i    (imm),
    .result_o (alu_result)
  );

  assign issue = in_valid & ~flush;

  // Payload only loads behind a live valid, so the last broadcast value holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0].valid <= issue;
      if (issue) begin
        stage_q[0].rob_idx <= rob_idx;
        stage_q[0].result  <= alu_result;
      end
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i].valid <= stage_q[i-1].valid & ~flush;
        if (stage_q[i-1].valid && !flush) begin
          stage_q[i].rob_idx <= stage_q[i-1].rob_idx;
          stage_q[i].result  <= stage_q[i-1].result;
        end
      end
    end
  end

  assign cdb_valid   = stage_q[LATENCY-1].valid;
  assign cdb_rob_idx = stage_q[LATENCY-1].rob_idx;
  assign cdb_result  = stage_q[LATENCY-1].result;

endmodule

// File: tb/tb_fxu_exec.sv
// Directed bench for fxu_exec: opcode vector table plus flush, hold and reset sequences.
module tb_fxu_exec;
  import core_pkg::*;

  localparam int unsigned LAT = 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flush;
  logic [OPC_W-1:0]     opcode;
  logic [ROB_IDX_W-1:0] rob_idx;
  logic                 in_valid;
  logic [DATA_W-1:0]    op1;
  logic [DATA_W-1:0]    op2;
  logic [IMM_W-1:0]     imm;
  logic                 cdb_valid;
  logic [ROB_IDX_W-1:0] cdb_rob_idx;
  logic [DATA_W-1:0]    cdb_result;

  int n_tests = 0;
  int n_fail  = 0;

  logic [ROB_IDX_W-1:0] pulse_tag [$];
  logic [DATA_W-1:0]    pulse_res [$];

  fxu_exec #(.LATENCY(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .opcode      (opcode),
    .rob_idx     (rob_idx),
    .in_valid    (in_valid),
    .op1         (op1),
    .op2         (op2),
    .imm         (imm),
    .cdb_valid   (cdb_valid),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_result  (cdb_result)
  );

  always #5 clk = ~clk;

  // Mid-cycle CDB monitor: one entry per cycle that cdb_valid is high.
  always @(negedge clk) begin
    if (cdb_valid === 1'b1) begin
      pulse_tag.push_back(cdb_rob_idx);
      pulse_res.push_back(cdb_result);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [OPC_W-1:0]     opc;
    logic [ROB_IDX_W-1:0] tag;
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
    logic [IMM_W-1:0]     im;
    logic [DATA_W-1:0]    exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [OPC_W-1:0] opc, input logic [ROB_IDX_W-1:0] tag,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [IMM_W-1:0] im);
    in_valid = 1'b1;
    opcode   = opc;
    rob_idx  = tag;
    op1      = a;
    op2      = b;
    imm      = im;
  endtask

  task automatic clear_pulses();
    pulse_tag.delete();
    pulse_res.delete();
  endtask

  initial begin
    vecs[0] = '{4'h0, 4'd3,  16'h0005, 16'h0007, 8'h00, 16'hFFFE};
    vecs[1] = '{4'h0, 4'd10, 16'h0000, 16'h0001, 8'hAA, 16'hFFFF};
    vecs[2] = '{4'h0, 4'd11, 16'h8000, 16'h0001, 8'h00, 16'h7FFF};
    vecs[3] = '{4'h8, 4'd5,  16'h1234, 16'h5678, 8'h80, 16'hFF80};
    vecs[4] = '{4'h8, 4'd12, 16'hFFFF, 16'hFFFF, 8'h7F, 16'h007F};
    vecs[5] = '{4'h9, 4'd6,  16'hAB34, 16'h0000, 8'h12, 16'h1234};
    vecs[6] = '{4'h9, 4'd15, 16'h00FF, 16'h1111, 8'hC3, 16'hC3FF};
    vecs[7] = '{4'h1, 4'd13, 16'h1234, 16'h0001, 8'h55, 16'h0000};
    vecs[8] = '{4'hF, 4'd14, 16'hFFFF, 16'hFFFF, 8'hFF, 16'h0000};

    // Reset held with in_valid high: nothing may appear on the lane.
    rst_n = 1'b0;
    flush = 1'b0;
    drive(4'h0, 4'd3, 16'h0005, 16'h0007, 8'h00);
    for (int c = 0; c < 2; c++) begin
      step();
      check("reset_valid", 32'(cdb_valid), 32'd0);
      check("reset_tag", 32'(cdb_rob_idx), 32'd0);
      check("reset_result", 32'(cdb_result), 32'd0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();

    for (int v = 0; v < 9; v++) begin
      drive(vecs[v].opc, vecs[v].tag, vecs[v].a, vecs[v].b, vecs[v].im);
      step();
      in_valid = 1'b0;
      for (int k = 1; k < int'(LAT); k++) step();
      check($sformatf("vec%0d_valid", v), 32'(cdb_valid), 32'd1);
      check($sformatf("vec%0d_tag", v), 32'(cdb_rob_idx), 32'(vecs[v].tag));
      check($sformatf("vec%0d_result", v), 32'(cdb_result), 32'(vecs[v].exp));
      step();
      check($sformatf("vec%0d_drop", v), 32'(cdb_valid), 32'd0);
      check($sformatf("vec%0d_hold", v), 32'(cdb_result), 32'(vecs[v].exp));
    end

    // Back-to-back MOVL tag 5 then MOVH tag 6: two consecutive pulses in order.
    clear_pulses();
    drive(OPC_MOVL, 4'd5, 16'h0000, 16'h0000, 8'h80);
    step();
    drive(OPC_MOVH, 4'd6, 16'hAB34, 16'h0000, 8'h12);
    step();
    in_valid = 1'b0;
    repeat (LAT + 1) step();
    check("b2b_count", 32'(pulse_tag.size()), 32'd2);
    if (pulse_tag.size() == 2) begin
      check("b2b_tag0", 32'(pulse_tag[0]), 32'd5);
      check("b2b_res0", 32'(pulse_res[0]), 32'hFF80);
      check("b2b_tag1", 32'(pulse_tag[1]), 32'd6);
      check("b2b_res1", 32'(pulse_res[1]), 32'h1234);
    end

    // Flush: tag 2 issued, flush with tag 4 next cycle, then tag 7 after flush drops.
    clear_pulses();
    drive(OPC_SUB, 4'd2, 16'h0009, 16'h0002, 8'h00);
    step();
    flush = 1'b1;
    drive(OPC_SUB, 4'd4, 16'h0001, 16'h0001, 8'h00);
    step();
    check("flush_valid", 32'(cdb_valid), 32'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    drive(OPC_MOVL, 4'd7, 16'h0000, 16'h0000, 8'h07);
    step();
    in_valid = 1'b0;
    repeat (LAT + 1) step();
    // With a single stage tag 2 reaches the lane before the flush edge.
    check("flush_count", 32'(pulse_tag.size()), (LAT == 1) ? 32'd2 : 32'd1);
    if (pulse_tag.size() > 0) begin
      check("flush_last_tag", 32'(pulse_tag[pulse_tag.size()-1]), 32'd7);
      check("flush_last_res", 32'(pulse_res[pulse_res.size()-1]), 32'h0007);
      check("flush_first_tag", 32'(pulse_tag[0]), (LAT == 1) ? 32'd2 : 32'd7);
    end

    // Bubble/hold: one pulse, then result and tag persist with valid low.
    clear_pulses();
    drive(OPC_MOVL, 4'd1, 16'h0000, 16'h0000, 8'h01);
    step();
    in_valid = 1'b0;
    repeat (LAT + 3) step();
    check("hold_count", 32'(pulse_tag.size()), 32'd1);
    check("hold_valid", 32'(cdb_valid), 32'd0);
    check("hold_result", 32'(cdb_result), 32'h0001);
    check("hold_tag", 32'(cdb_rob_idx), 32'd1);

    // Async reset between edges: lane clears at once, pending op never appears.
    drive(OPC_SUB, 4'd9, 16'h0003, 16'h0001, 8'h00);
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_valid", 32'(cdb_valid), 32'd0);
    check("areset_tag", 32'(cdb_rob_idx), 32'd0);
    check("areset_result", 32'(cdb_result), 32'd0);
    clear_pulses();
    step();
    rst_n = 1'b1;
    repeat (LAT + 2) step();
    check("areset_no_pulse", 32'(pulse_tag.size()), 32'd0);
    check("areset_result_after", 32'(cdb_result), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
